// File: rtl/id_ex_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_issue_stage                                            |
// | Description : ID/EX pipeline register with EX-side operand forwarding,     |
// |               ALU-control decode and load-use hazard stall generation.     |
// |               Forwarding is built in when ID_EX_FORWARD_EN is defined.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module id_ex_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_dataA,
  output logic [DW-1:0] alu_dataB,
  output logic [2:0]    alu_signal,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_illegal,
  output logic          hazard_stall
);

  localparam logic [2:0] c_sig_and = 3'b000;
  localparam logic [2:0] c_sig_or  = 3'b001;
  localparam logic [2:0] c_sig_add = 3'b010;
  localparam logic [2:0] c_sig_sub = 3'b110;
  localparam logic [2:0] c_sig_slt = 3'b111;

  logic          r_valid, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
  logic          r_illegal, r_alu_src;
  logic [2:0]    r_signal;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
  logic [RW-1:0] r_rs, r_rt, r_dest;

  logic [2:0]    w_signal;
  logic          w_illegal;
  logic          w_load_use, w_raw_stall, w_bubble, w_load;
  logic [DW-1:0] w_opa, w_opb;

  always_comb begin
    w_signal  = c_sig_add;
    w_illegal = 1'b0;
    case (id_alu_op)
      2'b01: w_signal = c_sig_sub;
      2'b10: begin
        case (id_funct)
          6'b100000: w_signal = c_sig_add;
          6'b100010: w_signal = c_sig_sub;
          6'b100100: w_signal = c_sig_and;
          6'b100101: w_signal = c_sig_or;
          6'b101010: w_signal = c_sig_slt;
          default:   w_illegal = 1'b1;
        endcase
      end
      default: w_signal = c_sig_add;
    endcase
  end

  assign w_load_use = r_valid & r_mem_read & id_valid & (r_dest != '0) &
                      ((r_dest == id_rs) | (r_dest == id_rt));

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    w_opa = r_rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
      w_opa = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
      w_opa = memwb_result;
    w_opb = r_rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
      w_opb = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
      w_opb = memwb_result;
  end
  assign w_raw_stall = 1'b0;
`else
  logic w_rs_dep, w_rt_dep;
  logic w_unused_fwd;

  assign w_opa = r_rs_data;
  assign w_opb = r_rt_data;
  // Without bypass paths any in-flight producer of a source must drain first
  assign w_rs_dep = (id_rs != '0) &
                    ((r_valid & r_reg_write & (r_dest == id_rs)) |
                     (exmem_reg_write & (exmem_rd == id_rs)));
  assign w_rt_dep = (id_rt != '0) &
                    ((r_valid & r_reg_write & (r_dest == id_rt)) |
                     (exmem_reg_write & (exmem_rd == id_rt)));
  assign w_raw_stall = id_valid & (w_rs_dep | w_rt_dep);
  assign w_unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, r_rs, r_rt};
`endif

  assign hazard_stall = ~flush & (w_load_use | w_raw_stall);
  assign w_bubble     = flush | (~hold & hazard_stall);
  assign w_load       = ~flush & ~hold & ~hazard_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_illegal    <= 1'b0;
      r_signal     <= c_sig_add;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_illegal    <= 1'b0;
      r_signal     <= c_sig_add;
    end else if (w_load) begin
      r_valid      <= id_valid;
      r_reg_write  <= id_valid & id_reg_write;
      r_mem_read   <= id_valid & id_mem_read;
      r_mem_write  <= id_valid & id_mem_write;
      r_mem_to_reg <= id_valid & id_mem_to_reg;
      r_illegal    <= id_valid & w_illegal;
      r_signal     <= id_valid ? w_signal : c_sig_add;
    end
  end

  // Datapath fields only matter while the control side says the slot is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
      r_alu_src <= 1'b0;
    end else if (w_load) begin
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_dest    <= id_reg_dst ? id_rd : id_rt;
      r_alu_src <= id_alu_src;
    end
  end

  assign alu_dataA     = w_opa;
  assign alu_dataB     = r_alu_src ? r_imm : w_opb;
  assign ex_store_data = w_opb;
  assign alu_signal    = r_signal;
  assign ex_dest       = r_dest;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_issue_stage.sv
`default_nettype none
// Directed and randomized bench for id_ex_issue_stage, checked against an
// instruction-level reference model of the EX slot.
module tb_id_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_dataA, alu_dataB, ex_store_data;
  logic [2:0]  alu_signal;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
  logic        hazard_stall;

  id_ex_issue_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v, rw, mr, mw, m2r, ill, src, known;
    bit [2:0]  sig;
    bit [31:0] a, b, imm;
    bit [4:0]  rs, rt, dst;
  } ex_t;

  ex_t m;
  int  n_assert = 0;
  int  n_fail   = 0;
  bit  fwd_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {illegal, signal} straight from the opcode/funct table
  function automatic bit [3:0] spec_decode(input bit [1:0] op, input bit [5:0] f);
    if (op == 2'b01) return 4'b0_110;
    if (op != 2'b10) return 4'b0_010;
    case (f)
      6'h20:   return 4'b0_010;
      6'h22:   return 4'b0_110;
      6'h24:   return 4'b0_000;
      6'h25:   return 4'b0_001;
      6'h2a:   return 4'b0_111;
      default: return 4'b1_010;
    endcase
  endfunction

  function automatic bit [31:0] model_fwd(input bit [4:0] idx, input bit [31:0] regval);
    if (fwd_en && idx != 0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (fwd_en && idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
    return regval;
  endfunction

  function automatic bit model_stall();
    bit lu, raw;
    if (flush) return 1'b0;
    lu  = m.v && m.mr && id_valid && m.dst != 0 && (m.dst == id_rs || m.dst == id_rt);
    raw = 1'b0;
    if (!fwd_en && id_valid) begin
      if (id_rs != 0 && ((m.v && m.rw && m.dst == id_rs) || (exmem_reg_write && exmem_rd == id_rs))) raw = 1'b1;
      if (id_rt != 0 && ((m.v && m.rw && m.dst == id_rt) || (exmem_reg_write && exmem_rd == id_rt))) raw = 1'b1;
    end
    return lu || raw;
  endfunction

  task automatic reset_model();
    m = '{default: 0};
    m.sig   = 3'b010;
    m.known = 1'b1;
  endtask

  task automatic bubble_model();
    m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.ill = 0;
    m.sig = 3'b010; m.known = 1'b0;
  endtask

  task automatic model_edge();
    bit        st;
    bit [3:0]  d;
    st = model_stall();
    if (rst) begin reset_model(); return; end
    if (flush) bubble_model();
    else if (!hold) begin
      if (st || !id_valid) bubble_model();
      else begin
        d = spec_decode(id_alu_op, id_funct);
        m.v = 1; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
        m.m2r = id_mem_to_reg; m.ill = d[3]; m.sig = d[2:0]; m.src = id_alu_src;
        m.a = id_rs_data; m.b = id_rt_data; m.imm = id_imm; m.rs = id_rs; m.rt = id_rt;
        m.dst = id_reg_dst ? id_rd : id_rt; m.known = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("ex_valid", ex_valid, m.v);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_mem_to_reg", ex_mem_to_reg, m.m2r);
    chk("ex_illegal", ex_illegal, m.ill);
    chk("alu_signal", alu_signal, m.sig);
    chk("hazard_stall", hazard_stall, model_stall());
    if (m.known) begin
      chk("ex_dest", ex_dest, m.dst);
      chk("alu_dataA", alu_dataA, model_fwd(m.rs, m.a));
      chk("alu_dataB", alu_dataB, m.src ? m.imm : model_fwd(m.rt, m.b));
      chk("ex_store_data", ex_store_data, model_fwd(m.rt, m.b));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst) reset_model();
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [1:0] op, input bit [5:0] f,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit src, input bit rdst, input bit rw, input bit mr,
                        input bit mw, input bit m2r);
    id_valid = v; id_alu_op = op; id_funct = f; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = src; id_reg_dst = rdst;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  logic [5:0] flist[6];
  logic [2:0] slist[6];

  initial begin
`ifdef ID_EX_FORWARD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    flist = '{6'b101010, 6'b100100, 6'b100101, 6'b100010, 6'b100000, 6'b111111};
    slist = '{3'b111, 3'b000, 3'b001, 3'b110, 3'b010, 3'b010};
    rst = 1; hold = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
    #12;
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset alu_signal", alu_signal, 3'b010);
    chk("reset ex_dest", ex_dest, 5'd0);
    chk("reset ex_illegal", ex_illegal, 1'b0);
    chk("reset alu_dataA", alu_dataA, 32'd0);
    reset_model();
    cycle();
    rst = 0;

    // R-type decode sweep
    for (int i = 0; i < 6; i++) begin
      set_id(1, 2'b10, flist[i], 5'd1, 5'd2, 5'd5, 32'h10 + i, 32'h20 + i, 0, 0, 1, 1, 0, 0, 0);
      cycle();
      chk("rtype signal", alu_signal, slist[i]);
      chk("rtype illegal", ex_illegal, (i == 5) ? 1'b1 : 1'b0);
    end

    // forwarding priority on rs
    set_id(1, 2'b00, 0, 5'd3, 5'd2, 5'd0, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    id_valid = 0; hold = 1;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h0000_5555;
    #1 chk("fwd exmem wins", alu_dataA, fwd_en ? 32'hAAAA_0000 : 32'h1111_1111);
    cycle();
    exmem_reg_write = 0;
    #1 chk("fwd memwb", alu_dataA, fwd_en ? 32'h0000_5555 : 32'h1111_1111);
    cycle();
    clear_fwd(); hold = 0;
    set_id(1, 2'b00, 0, 5'd0, 5'd2, 5'd0, 32'h3333_3333, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    id_valid = 0; hold = 1;
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD_BEEF;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hFEED_F00D;
    #1 chk("no fwd r0", alu_dataA, 32'h3333_3333);
    cycle();
    clear_fwd(); hold = 0;

    // load-use: lw $4 followed by a consumer of $4
    set_id(1, 2'b00, 0, 5'd1, 5'd4, 5'd0, 32'h100, 0, 32'h8, 1, 0, 1, 1, 0, 1);
    cycle();
    set_id(1, 2'b10, 6'h20, 5'd4, 5'd2, 5'd6, 32'h44, 32'h22, 0, 0, 1, 1, 0, 0, 0);
    #1 chk("load-use stall", hazard_stall, 1'b1);
    cycle();
    chk("load-use bubble", ex_valid, 1'b0);
    chk("load-use stall drop", hazard_stall, 1'b0);
    cycle();
    chk("load-use issue", ex_valid, 1'b1);
    chk("load-use issue dest", ex_dest, 5'd6);

    // hold freezes the slot while ID churns
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom);
      cycle();
      chk("hold valid", ex_valid, 1'b1);
      chk("hold dest", ex_dest, 5'd6);
      chk("hold signal", alu_signal, 3'b010);
    end
    flush = 1;
    cycle();
    chk("hold+flush bubble", ex_valid, 1'b0);
    flush = 0; hold = 0;

    // flush masks a pending load-use stall
    set_id(1, 2'b00, 0, 5'd1, 5'd4, 5'd0, 32'h100, 0, 32'h8, 1, 0, 1, 1, 0, 1);
    cycle();
    set_id(1, 2'b10, 6'h20, 5'd4, 5'd2, 5'd6, 32'h44, 32'h22, 0, 0, 1, 1, 0, 0, 0);
    flush = 1;
    #1 chk("flush kills stall", hazard_stall, 1'b0);
    cycle();
    flush = 0;

    // immediate path versus store data
    set_id(1, 2'b00, 0, 5'd1, 5'd6, 5'd0, 32'h50, 32'h999, 32'hFFFF_FFF0, 1, 0, 0, 0, 1, 0);
    cycle();
    id_valid = 0; hold = 1;
    memwb_reg_write = 1; memwb_rd = 5'd6; memwb_result = 32'h1234;
    #1 chk("imm dataB", alu_dataB, 32'hFFFF_FFF0);
    chk("imm store data", ex_store_data, fwd_en ? 32'h1234 : 32'h999);
    cycle();
    clear_fwd(); hold = 0;

    // asynchronous reset in the middle of a load-use pair
    set_id(1, 2'b00, 0, 5'd1, 5'd4, 5'd0, 32'h100, 0, 32'h8, 1, 0, 1, 1, 0, 1);
    cycle();
    set_id(1, 2'b10, 6'h20, 5'd4, 5'd2, 5'd6, 32'h44, 32'h22, 0, 0, 1, 1, 0, 0, 0);
    #1 chk("pre-reset stall", hazard_stall, 1'b1);
    #2 rst = 1;
    #1 chk("async rst valid", ex_valid, 1'b0);
    chk("async rst signal", alu_signal, 3'b010);
    chk("async rst stall", hazard_stall, 1'b0);
    chk("async rst mem_read", ex_mem_read, 1'b0);
    cycle();
    rst = 0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 4) != 0) ? flist[$urandom_range(0, 5)] : 6'($urandom),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom);
      exmem_reg_write = $urandom; exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = $urandom; memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0; hold = 0; flush = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding and ALU-control decode.
- Sits directly upstream of the 32-bit ALU and drives its dataA, dataB and 3-bit Signal.
- Also generates the load-use hazard stall back to IF/ID.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  external freeze (memory stall); stage keeps contents.
- flush  in  1  branch/exception squash; loads a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data, id_imm  in  DW  register-file reads and sign-extended immediate.
- id_rs, id_rt, id_rd  in  RW  source and destination indices.
- id_alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type use funct, 11 reserved.
- id_funct  in  6  R-type funct field.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  ID control.
- exmem_reg_write  in  1,  exmem_rd  in  RW,  exmem_result  in  DW  EX/MEM forward source.
- memwb_reg_write  in  1,  memwb_rd  in  RW,  memwb_result  in  DW  MEM/WB forward source.
- alu_dataA, alu_dataB  out  DW  ALU operands.
- alu_signal  out  3  ALU op: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- ex_store_data  out  DW  forwarded rt value for sw.
- ex_dest  out  RW  id_rd if reg_dst else id_rt, registered.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls.
- ex_illegal  out  1  registered: R-type funct not one of the five supported.
- hazard_stall  out  1  combinational; stalls IF/ID and PC.

Behaviour:
- Reset, async: all registers cleared. ex_valid=0, all controls 0, ex_dest=0, ex_illegal=0. Registered signal = 010; operands and data = 0.
- Per-edge priority:
  1. flush loads a bubble.
  2. else hold keeps state.
  3. else hazard_stall loads a bubble.
  4. else load ID fields.
- Bubble: valid, reg_write, mem_read, mem_write, mem_to_reg, illegal = 0; signal = 010; data fields don't-care.
- Controls are loaded already gated by id_valid. id_valid=0 equals bubble.
- Decode at load time, registered:
  - alu_op 00 -> 010; 01 -> 110; 11 -> 010.
  - alu_op 10, funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - Any other funct -> 010 with illegal=1.
- Forwarding, combinational on registered rs/rt, per operand:
  - If exmem_reg_write, exmem_rd!=0 and exmem_rd==rs, take exmem_result.
  - Else if the same conditions hold on memwb, take memwb_result.
  - Else take the registered register value.
  - EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
- alu_dataA = forwarded rs. alu_dataB = imm if alu_src, else forwarded rt. ex_store_data = forwarded rt always.
- hazard_stall = ex_valid & ex_mem_read & id_valid & (ex_dest==id_rs | ex_dest==id_rt) & ex_dest!=0.
- hazard_stall is 1 for exactly one cycle per load-use pair: the bubble clears ex_mem_read.
- hazard_stall is forced 0 while flush=1.
- Outputs are stable one cycle after load. Total ID->ALU latency is 1 clk.
- Reset asserted mid-instruction drops it with no partial state.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined: operands come from registered values only. hazard_stall additionally asserts when id_valid and (id_rs or id_rt, nonzero) matches either:
  - ex_dest with ex_valid & ex_reg_write; or
  - exmem_rd with exmem_reg_write.

Test Plan:
- Reset: rst=1 mid-load with hold=0 -> ex_valid=0, alu_signal=010, hazard_stall=0 immediately, without waiting for a clock.
- R-type decode: load funct 101010, then 100100, 100101, 100010, 100000, 111111 on successive cycles -> signal 111, 000, 001, 110, 010, then 010 with ex_illegal=1.
- Forward priority: ex rs=3; exmem_rd=3 result 0xAAAA0000; memwb_rd=3 result 0x5555 -> alu_dataA=0xAAAA0000. Drop exmem_reg_write -> 0x5555. Set rs=0 with exmem_rd=0 -> registered value.
- Load-use: ex lw to rt=4, next id uses rs=4 -> hazard_stall=1 one cycle, bubble inserted (ex_valid=0), then the instruction issues with hazard_stall=0.
- Hold/flush: hold=1 for 3 cycles with changing ID inputs -> outputs unchanged. hold=1 & flush=1 -> bubble. Flush during hazard -> hazard_stall=0.
- Immediate path: alu_src=1, imm=0xFFFFFFF0, rt forwarded 0x1234 -> alu_dataB=0xFFFFFFF0, ex_store_data=0x1234.
